// File: rtl/error_metric_accumulator16.sv
// error_metric_accumulator16: error statistics for a 16-bit approximate adder.
// Recomputes the exact sum and accumulates error count, error-distance sum and max.
//
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   start_i             clear statistics and open a window (IDLE/DONE only)
//   valid_i / ready_o   sample handshake; accepted when both high on an edge
//   add1_i, add2_i      operands as applied to the adder
//   approx_i            approximate adder result, carry-out in MSB
//   busy_o, done_o      window in progress / window complete
//   sample_cnt_o        samples accepted in the current window
//   err_cnt_o           samples whose approx_i differs from the exact sum
//   sum_ed_o            saturating sum of error distances
//   max_ed_o            largest error distance in the window
//
// Build option: define ERR_METRIC_MAXED_EN to build the max-error-distance
// tracker; without it max_ed_o is a constant 0.

module error_metric_accumulator16 #(
    parameter int WIDTH    = 16,
    parameter int NSAMPLES = 1024,
    parameter int CNTW     = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNTW-1:0]  sample_cnt_o,
    output logic [CNTW-1:0]  err_cnt_o,
    output logic [CNTW-1:0]  sum_ed_o,
    output logic [WIDTH:0]   max_ed_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Wide enough to hold the running sum plus one error distance.
    localparam int SW = ((CNTW > WIDTH + 1) ? CNTW : WIDTH + 1) + 1;
    localparam logic [SW-1:0] SUM_MAX = {{(SW - CNTW){1'b0}}, {CNTW{1'b1}}};
    localparam logic [CNTW-1:0] LAST = CNTW'(NSAMPLES - 1);

    state_t          state;
    logic            s1_vld;
    logic [WIDTH:0]  s1_exact;
    logic [WIDTH:0]  s1_approx;
    logic [WIDTH:0]  ed;
    logic [SW-1:0]   sum_wide;
    logic [CNTW-1:0] sum_sat;

    always_comb begin
        ed = '0;
        if (s1_exact >= s1_approx)
            ed = s1_exact - s1_approx;
        else
            ed = s1_approx - s1_exact;
    end

    assign sum_wide = SW'(sum_ed_o) + SW'(ed);
    assign sum_sat  = (sum_wide > SUM_MAX) ? {CNTW{1'b1}} : sum_wide[CNTW-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            ready_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            s1_vld       <= 1'b0;
            s1_exact     <= '0;
            s1_approx    <= '0;
            sample_cnt_o <= '0;
            err_cnt_o    <= '0;
            sum_ed_o     <= '0;
        end else begin
            // Stage 2: fold the registered sample into the statistics.
            if (s1_vld) begin
                if (ed != '0)
                    err_cnt_o <= err_cnt_o + 1'b1;
                sum_ed_o <= sum_sat;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state        <= RUN;
                        ready_o      <= 1'b1;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        s1_vld       <= 1'b0;
                        sample_cnt_o <= '0;
                        err_cnt_o    <= '0;
                        sum_ed_o     <= '0;
                    end
                end
                RUN: begin
                    // Stage 1: capture exact and approximate sums.
                    s1_vld <= valid_i;
                    if (valid_i) begin
                        s1_exact     <= {1'b0, add1_i} + {1'b0, add2_i};
                        s1_approx    <= approx_i;
                        sample_cnt_o <= sample_cnt_o + 1'b1;
                        if (sample_cnt_o == LAST) begin
                            state   <= DRAIN;
                            ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Leave only once the last sample has been folded in.
                    s1_vld <= 1'b0;
                    if (!s1_vld) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ERR_METRIC_MAXED_EN
    logic           clr;
    logic [WIDTH:0] max_q;

    assign clr = start_i && (state == IDLE || state == DONE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            max_q <= '0;
        else if (clr)
            max_q <= '0;
        else if (s1_vld && ed > max_q)
            max_q <= ed;
    end

    assign max_ed_o = max_q;
`else
    assign max_ed_o = '0;
`endif

endmodule

// File: doc/error_metric_accumulator16.md
# error_metric_accumulator16

Downstream measurement stage for the 16-bit approximate adders. It takes each operand pair together with the approximate adder's 17-bit result and recomputes the exact sum internally. It then accumulates error statistics over a window of NSAMPLES accepted samples: error count, sum of error distance and maximum error distance. The block sits directly after the adder's result output in characterisation benches and on-chip self-test wrappers.

## Interface
- WIDTH, 16, operand width; approximate result is WIDTH+1 bits
- NSAMPLES, 1024, samples per measurement window (1 to 2^CNTW-1)
- CNTW, 32, width of sample/error counters and of the error-distance sum
- clk_i  input  1  clock, all state updates on rising edge
- rstn_i  input  1  reset; one clock; reset is asynchronous and active-low
- start_i  input  1  clear statistics and open a new window (honoured in IDLE and DONE only)
- valid_i  input  1  sample present on add1_i/add2_i/approx_i
- ready_o  output  1  block accepts a sample this cycle
- add1_i  input  WIDTH  operand A as applied to the adder
- add2_i  input  WIDTH  operand B as applied to the adder
- approx_i  input  WIDTH+1  approximate adder result (carry-out in MSB)
- busy_o  output  1  window in progress (RUN or DRAIN)
- done_o  output  1  window complete, statistics stable
- sample_cnt_o  output  CNTW  samples accepted in current window
- err_cnt_o  output  CNTW  samples with approx_i != exact sum
- sum_ed_o  output  CNTW  sum of |exact - approx_i|, saturating
- max_ed_o  output  WIDTH+1  largest |exact - approx_i| in window

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE: ready_o=0. start_i clears all statistics and enters RUN.
- RUN: ready_o=1. A sample is accepted on a rising edge with valid_i=1. When the NSAMPLES-th sample is accepted, the FSM enters DRAIN and ready_o falls on the same edge. start_i is ignored.
- DRAIN: ready_o=0. The FSM waits one cycle for the pipeline to empty, then enters DONE. start_i is ignored.
- DONE: done_o=1, all statistics held. start_i clears the statistics and re-enters RUN on the same edge; done_o falls on that edge.
- Stage 1 (accept edge) registers three values: exact = add1_i + add2_i (WIDTH+1 bits, zero-extended), approx_i, and a stage-valid flag.
- Stage 2 (next edge) computes ed = |exact - approx| as an unsigned WIDTH+1 value, then updates the statistics:
  - err_cnt_o increments if ed != 0.
  - sum_ed_o adds ed and saturates at 2^CNTW-1.
  - max_ed_o is updated if ed > max_ed_o.
- sample_cnt_o increments on the accept edge itself.
- err_cnt_o and sample_cnt_o never wrap, because NSAMPLES < 2^CNTW.
- An input change while ready_o=0 has no effect.
- Reset values: ready_o=0, busy_o=0, done_o=0, all counters and statistics 0, pipeline flag 0.
- Asserting rstn_i mid-window aborts it immediately. No partial statistics are retained.

## Timing
- Sample accepted at edge k: sample_cnt_o updates at k; err_cnt_o, sum_ed_o and max_ed_o update at k+1.
- Last sample accepted at edge k: state is DRAIN after k, final statistics appear at k+1, done_o=1 from k+2.
- Throughput is one sample per cycle with no bubbles while valid_i is held high.
- start_i in DONE at edge j: statistics read 0 and ready_o=1 after j.

## Configuration
- ERR_METRIC_MAXED_EN defined: the max-error-distance comparator and register are built, and max_ed_o behaves as described above.
- ERR_METRIC_MAXED_EN undefined: no comparator or register is built, and max_ed_o is a constant 0. All other behaviour is unchanged.

## Test plan
- Reset then idle: rstn_i low for 3 cycles, then high with no start_i -> all outputs 0, ready_o=0.
- Exact window: NSAMPLES=4, start_i, four samples with approx_i equal to the exact sum (e.g. 0x0003+0x0004 with approx 0x00007) -> sample_cnt_o=4, err_cnt_o=0, sum_ed_o=0, max_ed_o=0, done_o=1 two cycles after the 4th accept.
- Error mix: NSAMPLES=3, samples (0xFFFF,0x0001,approx 0x0FFFF) ed=1, (0x00F0,0x0010,approx 0x000F0) ed=0x10, (0x1,0x1,approx 0x00002) ed=0 -> err_cnt_o=2, sum_ed_o=0x11, max_ed_o=0x10 (0 with the macro undefined).
- Back-pressure and gaps: valid_i toggled every other cycle, and extra valid_i held after NSAMPLES -> exactly NSAMPLES samples counted, ready_o=0 in DRAIN and DONE.
- Saturation: CNTW=8, NSAMPLES=4, each sample ed=0x80 -> sum_ed_o=0xFF, err_cnt_o=4.
- Restart and abort: start_i in DONE clears the statistics and restarts; rstn_i pulsed low after 2 of 4 samples -> returns to IDLE with all outputs 0, and the next start_i gives a clean window.
